multicycle_control32: RTL and testbench
=======================================

Name: multicycle_control32

Overview:
- Multi-cycle successor to the single-cycle control32 decoder for the Minisys-style 31-instruction MIPS core.
- Sequences every instruction through a fetch/decode/execute/memory/writeback FSM and drives datapath strobes only in the owning state.
- Waits on a memory/IO ready handshake, with a parametrised timeout and a parametrised IO-space decode.
- Sits between the IR (Opcode/Function_opcode) and the multi-cycle datapath (PC, IR, register file, ALU, memory/IO bus).

Parameters:
IO_HIGH_W, 22, width of the ALU-result high field compared for IO decode
IO_HIGH_VAL, {IO_HIGH_W{1'b1}}, high-field value that selects IO space
MEM_TIMEOUT, 15, cycles in MEM waiting on Mem_ready before abort; 0 = never time out

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
Opcode  in  6  IR[31:26]
Function_opcode  in  6  IR[5:0]
Alu_resultHigh  in  IO_HIGH_W  ALUOut high bits; stable throughout MEM
Zero  in  1  ALU zero flag; valid in EX
Mem_ready  in  1  memory/IO access complete this cycle
State  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4
IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IORead, IOWrite  out  1 each  state-gated strobes
PCSrc  out  2  0=PC+4, 1=branch target, 2=jump target, 3=register (jr); meaningful only when PCWrite=1
RegDST, ALUSrc, MemorIOtoReg, Jrn, Jal, Jmp, Branch, nBranch, I_format, Sftmd  out  1 each  level decode
ALUOp  out  2  {R_format|I_format, Branch|nBranch}
Illegal  out  1  one-cycle pulse on an undecodable opcode
Bus_error  out  1  one-cycle pulse on MEM timeout

Behaviour:
- Interface: one clock, clock; reset is synchronous and active-high, named reset.
- Reset: State=IF. While reset=1, every strobe, Illegal and Bus_error are forced 0 combinationally. Timeout counter clears to 0.
- Level decode is combinational from Opcode/Function_opcode, identical in meaning to the single-cycle unit:
  - I_format covers opcodes 08,09,0A,0B,0C,0D,0E,0F.
  - Lw=23h, Sw=2Bh, Branch=04h, nBranch=05h, Jmp=02h, Jal=03h.
  - Jrn = R-type with funct 08h.
  - Sftmd = R-type with funct 00,02,03,04,06,07.
  - RegDST = R-type. ALUSrc = I_format|Lw|Sw. MemorIOtoReg = Lw.
- Legal = R-type | I_format | Lw | Sw | Branch | nBranch | Jmp | Jal.
- PCWrite fires exactly once per instruction, on its final cycle. That cycle always returns to IF.
- FSM:
  - IF: IRWrite=1 -> ID.
  - ID:
    - Jmp: PCWrite=1, PCSrc=2 -> IF.
    - Jrn: PCWrite=1, PCSrc=3 -> IF.
    - Jal -> WB.
    - Illegal: Illegal=1, PCWrite=1, PCSrc=0 -> IF (instruction is a NOP).
    - Otherwise -> EX.
  - EX:
    - Branch/nBranch: PCWrite=1; PCSrc=1 if (Branch&Zero)|(nBranch&~Zero), else PCSrc=0 -> IF.
    - Lw/Sw -> MEM.
    - R-type/I_format -> WB.
  - MEM: io = (Alu_resultHigh==IO_HIGH_VAL).
    - Strobes held every MEM cycle: IORead=Lw&io, MemRead=Lw&~io, IOWrite=Sw&io, MemWrite=Sw&~io.
    - On Mem_ready=1: Lw -> WB; Sw: PCWrite=1, PCSrc=0 -> IF.
    - Counter increments each MEM cycle with Mem_ready=0. If MEM_TIMEOUT!=0 and the count equals MEM_TIMEOUT-1 while Mem_ready=0: Bus_error=1, PCWrite=1, PCSrc=0 -> IF, no RegWrite.
    - Counter clears on leaving MEM.
    - If Mem_ready and the timeout occur in the same cycle, ready wins.
  - WB: RegWrite=1, PCWrite=1.
    - PCSrc=2 for Jal (datapath writes PC+4 to $31); otherwise PCSrc=0.
    - -> IF.
- No stray writes: R-type Jrn never reaches WB, so RegWrite is never asserted for jr.
- Cycle counts:
  - j/jr/illegal: 2
  - beq/bne: 3
  - jal: 3
  - R/I: 4
  - sw: 4+wait
  - lw: 5+wait
- Reset mid-instruction (any state): next state IF. Strobes are 0 in the reset cycle, so no partial memory or register write completes.

Test Plan:
- reset, then add (Opcode=00, funct=20h) -> IRWrite@IF, WB on cycle 4 with RegWrite=1, RegDST=1, PCWrite=1, PCSrc=0; repeats every 4 cycles.
- lw, Alu_resultHigh=22'h3FFFFF, Mem_ready low 2 cycles then high -> IORead=1 for 3 MEM cycles, MemRead=0; WB RegWrite=1, MemorIOtoReg=1; 7 cycles total.
- sw, Alu_resultHigh=0, Mem_ready stuck 0, MEM_TIMEOUT=15 -> MemWrite=1 for 15 cycles, Bus_error pulse on the 15th, PCWrite=1, RegWrite never 1, back to IF.
- beq with Zero=1 -> EX PCWrite=1, PCSrc=1; bne with Zero=1 -> PCSrc=0; both 3 cycles, ALUOp=01.
- jal -> ID then WB: RegWrite=1, PCSrc=2. jr (funct 08h) -> ID PCWrite=1, PCSrc=3, RegWrite stays 0. Opcode=3Fh -> Illegal pulse, PCSrc=0.
- reset asserted in the 2nd MEM cycle of sw -> MemWrite=0 that cycle, State=IF next, counter=0.

Source files
------------

// File: rtl/multicycle_control32.sv
// Multi-cycle control FSM for the 31-instruction Minisys-style MIPS core: IF/ID/EX/MEM/WB
// sequencing, state-gated datapath strobes, memory/IO ready handshake with a timeout.
module multicycle_control32 #(
    parameter int                   IO_HIGH_W   = 22,
    parameter logic [IO_HIGH_W-1:0] IO_HIGH_VAL = {IO_HIGH_W{1'b1}},
    parameter int                   MEM_TIMEOUT = 15
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [5:0]           Opcode,
    input  logic [5:0]           Function_opcode,
    input  logic [IO_HIGH_W-1:0] Alu_resultHigh,
    input  logic                 Zero,
    input  logic                 Mem_ready,
    output logic [2:0]           State,
    output logic                 IRWrite,
    output logic                 PCWrite,
    output logic                 RegWrite,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 IORead,
    output logic                 IOWrite,
    output logic [1:0]           PCSrc,
    output logic                 RegDST,
    output logic                 ALUSrc,
    output logic                 MemorIOtoReg,
    output logic                 Jrn,
    output logic                 Jal,
    output logic                 Jmp,
    output logic                 Branch,
    output logic                 nBranch,
    output logic                 I_format,
    output logic                 Sftmd,
    output logic [1:0]           ALUOp,
    output logic                 Illegal,
    output logic                 Bus_error
);

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam int CNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    logic [2:0]       state, next_state;
    logic [CNT_W-1:0] wait_cnt;

    logic r_format, lw, sw, legal, io_space, timeout_hit;
    logic ir_write, pc_write, reg_write, mem_read, mem_write, io_read, io_write;
    logic illegal_pulse, bus_error_pulse;
    logic [1:0] pc_src;

    // Level decode, same meaning as the single-cycle control32.
    assign r_format     = (Opcode == 6'h00);
    assign lw           = (Opcode == 6'h23);
    assign sw           = (Opcode == 6'h2B);
    assign Branch       = (Opcode == 6'h04);
    assign nBranch      = (Opcode == 6'h05);
    assign Jmp          = (Opcode == 6'h02);
    assign Jal          = (Opcode == 6'h03);
    assign I_format     = (Opcode[5:3] == 3'b001);
    assign Jrn          = r_format && (Function_opcode == 6'h08);
    assign Sftmd        = r_format && (Function_opcode[5:3] == 3'b000) &&
                          (Function_opcode[2:0] != 3'd1) && (Function_opcode[2:0] != 3'd5);
    assign RegDST       = r_format;
    assign ALUSrc       = I_format || lw || sw;
    assign MemorIOtoReg = lw;
    assign ALUOp        = {r_format || I_format, Branch || nBranch};
    assign legal        = r_format || I_format || lw || sw || Branch || nBranch || Jmp || Jal;

    assign io_space    = (Alu_resultHigh == IO_HIGH_VAL);
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        next_state      = state;
        ir_write        = 1'b0;
        pc_write        = 1'b0;
        reg_write       = 1'b0;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        io_read         = 1'b0;
        io_write        = 1'b0;
        pc_src          = 2'd0;
        illegal_pulse   = 1'b0;
        bus_error_pulse = 1'b0;
        case (state)
            S_IF: begin
                ir_write   = 1'b1;
                next_state = S_ID;
            end
            S_ID: begin
                if (Jmp) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd2;
                    next_state = S_IF;
                end else if (Jrn) begin
                    pc_write   = 1'b1;
                    pc_src     = 2'd3;
                    next_state = S_IF;
                end else if (Jal) begin
                    next_state = S_WB;
                end else if (!legal) begin
                    illegal_pulse = 1'b1;
                    pc_write      = 1'b1;
                    next_state    = S_IF;
                end else begin
                    next_state = S_EX;
                end
            end
            S_EX: begin
                if (Branch || nBranch) begin
                    pc_write   = 1'b1;
                    pc_src     = ((Branch && Zero) || (nBranch && !Zero)) ? 2'd1 : 2'd0;
                    next_state = S_IF;
                end else if (lw || sw) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                io_read   = lw && io_space;
                mem_read  = lw && !io_space;
                io_write  = sw && io_space;
                mem_write = sw && !io_space;
                // Ready takes priority over a timeout landing in the same cycle.
                if (Mem_ready) begin
                    if (lw) begin
                        next_state = S_WB;
                    end else begin
                        pc_write   = 1'b1;
                        next_state = S_IF;
                    end
                end else if (timeout_hit) begin
                    bus_error_pulse = 1'b1;
                    pc_write        = 1'b1;
                    next_state      = S_IF;
                end
            end
            S_WB: begin
                reg_write  = 1'b1;
                pc_write   = 1'b1;
                pc_src     = Jal ? 2'd2 : 2'd0;
                next_state = S_IF;
            end
            default: next_state = S_IF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IF;
            wait_cnt <= '0;
        end else begin
            state <= next_state;
            if (state == S_MEM && next_state == S_MEM && !Mem_ready)
                wait_cnt <= wait_cnt + CNT_W'(1);
            else
                wait_cnt <= '0;
        end
    end

    // Reset masks every strobe so no partial write completes in the reset cycle.
    assign State     = state;
    assign PCSrc     = pc_src;
    assign IRWrite   = ir_write        && !reset;
    assign PCWrite   = pc_write        && !reset;
    assign RegWrite  = reg_write       && !reset;
    assign MemRead   = mem_read        && !reset;
    assign MemWrite  = mem_write       && !reset;
    assign IORead    = io_read         && !reset;
    assign IOWrite   = io_write        && !reset;
    assign Illegal   = illegal_pulse   && !reset;
    assign Bus_error = bus_error_pulse && !reset;

endmodule

// File: tb/tb_multicycle_control32.sv
// Directed self-checking bench for multicycle_control32: walks each instruction class
// through the FSM and checks strobes cycle by cycle against hand-computed values.
module tb_multicycle_control32;

    logic        clock = 1'b0;
    logic        reset;
    logic [5:0]  Opcode, Function_opcode;
    logic [21:0] Alu_resultHigh;
    logic        Zero, Mem_ready;
    logic [2:0]  State;
    logic        IRWrite, PCWrite, RegWrite, MemRead, MemWrite, IORead, IOWrite;
    logic [1:0]  PCSrc, ALUOp;
    logic        RegDST, ALUSrc, MemorIOtoReg, Jrn, Jal, Jmp, Branch, nBranch, I_format, Sftmd;
    logic        Illegal, Bus_error;

    int tests_run = 0;
    int tests_failed = 0;

    multicycle_control32 #(.IO_HIGH_W(22), .IO_HIGH_VAL(22'h3FFFFF), .MEM_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset), .Opcode(Opcode), .Function_opcode(Function_opcode),
        .Alu_resultHigh(Alu_resultHigh), .Zero(Zero), .Mem_ready(Mem_ready), .State(State),
        .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .IORead(IORead), .IOWrite(IOWrite), .PCSrc(PCSrc),
        .RegDST(RegDST), .ALUSrc(ALUSrc), .MemorIOtoReg(MemorIOtoReg), .Jrn(Jrn), .Jal(Jal),
        .Jmp(Jmp), .Branch(Branch), .nBranch(nBranch), .I_format(I_format), .Sftmd(Sftmd),
        .ALUOp(ALUOp), .Illegal(Illegal), .Bus_error(Bus_error)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance one clock; sample 2 time units after the rising edge.
    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        Opcode = op;
        Function_opcode = fn;
        #1;
    endtask

    // From IF, run IF/ID/EX and land in the first MEM cycle.
    task automatic to_mem();
        check("to_mem_if", 32'(State), 32'd0);
        step(); step(); step();
        check("to_mem_state", 32'(State), 32'd3);
    endtask

    initial begin
        reset = 1'b1; Opcode = 6'h00; Function_opcode = 6'h20;
        Alu_resultHigh = '0; Zero = 1'b0; Mem_ready = 1'b0;
        step();
        check("rst_state", 32'(State), 32'd0);
        check("rst_irwrite", 32'(IRWrite), 32'd0);
        check("rst_pcwrite", 32'(PCWrite), 32'd0);
        reset = 1'b0; #1;

        // add: 4 cycles, twice back to back.
        for (int rep = 0; rep < 2; rep++) begin
            check("add_if_state", 32'(State), 32'd0);
            check("add_if_irwrite", 32'(IRWrite), 32'd1);
            step();
            check("add_id_pcwrite", 32'(PCWrite), 32'd0);
            step();
            check("add_ex_state", 32'(State), 32'd2);
            check("add_ex_aluop", 32'(ALUOp), 32'd2);
            step();
            check("add_wb_state", 32'(State), 32'd4);
            check("add_wb_regwrite", 32'(RegWrite), 32'd1);
            check("add_wb_regdst", 32'(RegDST), 32'd1);
            check("add_wb_pcwrite", 32'(PCWrite), 32'd1);
            check("add_wb_pcsrc", 32'(PCSrc), 32'd0);
            step();
        end

        // Level decode spot checks.
        instr(6'h00, 6'h03);
        check("sra_sftmd", 32'(Sftmd), 32'd1);
        instr(6'h00, 6'h05);
        check("f05_sftmd", 32'(Sftmd), 32'd0);
        instr(6'h0D, 6'h00);
        check("ori_iformat", 32'(I_format), 32'd1);
        check("ori_alusrc", 32'(ALUSrc), 32'd1);
        check("ori_aluop", 32'(ALUOp), 32'd2);
        check("ori_regdst", 32'(RegDST), 32'd0);

        // lw to IO space, ready after 2 wait cycles: 7 cycles total.
        instr(6'h23, 6'h00);
        Alu_resultHigh = 22'h3FFFFF; #1;
        to_mem();
        for (int i = 0; i < 3; i++) begin
            if (i == 2) begin Mem_ready = 1'b1; #1; end
            check("lw_ioread", 32'(IORead), 32'd1);
            check("lw_memread", 32'(MemRead), 32'd0);
            check("lw_mem_pcwrite", 32'(PCWrite), 32'd0);
            check("lw_mem_state", 32'(State), 32'd3);
            step();
        end
        Mem_ready = 1'b0; #1;
        check("lw_wb_state", 32'(State), 32'd4);
        check("lw_wb_regwrite", 32'(RegWrite), 32'd1);
        check("lw_wb_memtoreg", 32'(MemorIOtoReg), 32'd1);
        check("lw_wb_pcwrite", 32'(PCWrite), 32'd1);
        step();
        check("lw_done_state", 32'(State), 32'd0);

        // sw to memory, ready stuck low: Bus_error on the 15th MEM cycle.
        instr(6'h2B, 6'h00);
        Alu_resultHigh = '0; #1;
        to_mem();
        for (int i = 0; i < 15; i++) begin
            check("sw_to_memwrite", 32'(MemWrite), 32'd1);
            check("sw_to_iowrite", 32'(IOWrite), 32'd0);
            check("sw_to_regwrite", 32'(RegWrite), 32'd0);
            check("sw_to_buserr", 32'(Bus_error), (i == 14) ? 32'd1 : 32'd0);
            check("sw_to_pcwrite", 32'(PCWrite), (i == 14) ? 32'd1 : 32'd0);
            step();
        end
        check("sw_to_state", 32'(State), 32'd0);
        check("sw_to_buserr_gone", 32'(Bus_error), 32'd0);

        // beq taken, bne not taken (Zero=1): 3 cycles each.
        Zero = 1'b1;
        instr(6'h04, 6'h00);
        step(); step();
        check("beq_state", 32'(State), 32'd2);
        check("beq_pcwrite", 32'(PCWrite), 32'd1);
        check("beq_pcsrc", 32'(PCSrc), 32'd1);
        check("beq_aluop", 32'(ALUOp), 32'd1);
        step();
        check("beq_done", 32'(State), 32'd0);
        instr(6'h05, 6'h00);
        step(); step();
        check("bne_pcwrite", 32'(PCWrite), 32'd1);
        check("bne_pcsrc", 32'(PCSrc), 32'd0);
        check("bne_aluop", 32'(ALUOp), 32'd1);
        step();
        check("bne_done", 32'(State), 32'd0);
        Zero = 1'b0; #1;

        // jal: IF, ID, WB.
        instr(6'h03, 6'h00);
        step();
        check("jal_id_pcwrite", 32'(PCWrite), 32'd0);
        step();
        check("jal_wb_state", 32'(State), 32'd4);
        check("jal_wb_regwrite", 32'(RegWrite), 32'd1);
        check("jal_wb_pcsrc", 32'(PCSrc), 32'd2);
        step();

        // jr: 2 cycles, never writes the register file.
        instr(6'h00, 6'h08);
        check("jr_jrn", 32'(Jrn), 32'd1);
        step();
        check("jr_pcwrite", 32'(PCWrite), 32'd1);
        check("jr_pcsrc", 32'(PCSrc), 32'd3);
        check("jr_regwrite", 32'(RegWrite), 32'd0);
        step();
        check("jr_done", 32'(State), 32'd0);

        // j: 2 cycles.
        instr(6'h02, 6'h00);
        step();
        check("j_pcwrite", 32'(PCWrite), 32'd1);
        check("j_pcsrc", 32'(PCSrc), 32'd2);
        step();
        check("j_done", 32'(State), 32'd0);

        // Undecodable opcode.
        instr(6'h3F, 6'h00);
        check("ill_if_pulse", 32'(Illegal), 32'd0);
        step();
        check("ill_pulse", 32'(Illegal), 32'd1);
        check("ill_pcwrite", 32'(PCWrite), 32'd1);
        check("ill_pcsrc", 32'(PCSrc), 32'd0);
        step();
        check("ill_done_state", 32'(State), 32'd0);
        check("ill_done_pulse", 32'(Illegal), 32'd0);

        // Reset in the 2nd MEM cycle of sw.
        instr(6'h2B, 6'h00);
        to_mem();
        step();
        check("swr_mem2_memwrite", 32'(MemWrite), 32'd1);
        reset = 1'b1; #1;
        check("swr_rst_memwrite", 32'(MemWrite), 32'd0);
        step();
        check("swr_rst_state", 32'(State), 32'd0);
        reset = 1'b0; #1;

        // Cleared counter: ready on the 15th cycle wins over the timeout.
        to_mem();
        for (int i = 0; i < 15; i++) begin
            if (i == 14) begin Mem_ready = 1'b1; #1; end
            check("swp_buserr", 32'(Bus_error), 32'd0);
            check("swp_pcwrite", 32'(PCWrite), (i == 14) ? 32'd1 : 32'd0);
            step();
        end
        Mem_ready = 1'b0; #1;
        check("swp_done_state", 32'(State), 32'd0);
        check("swp_regwrite", 32'(RegWrite), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
